// File: rtl/vending_machine_def_pkg.sv
// Shared constants, value tables and state encoding for the vending machine datapath.
package vending_machine_def;

    localparam int kNumCoins  = 3;
    localparam int kNumItems  = 4;
    localparam int kTotalBits = 31;
    localparam int kWaitTime  = 10;
    localparam int kWaitBits  = $clog2(kWaitTime + 1);

    localparam int unsigned kCoinValue [kNumCoins] = '{100, 500, 1000};
    localparam int unsigned kItemPrice [kNumItems] = '{400, 500, 1000, 2000};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        RETURN = 2'b10
    } state_e;

    // Isolates the lowest set bit; several simultaneous requests collapse to one.
    function automatic logic [kNumItems-1:0] lowest_onehot(input logic [kNumItems-1:0] v);
        return v & (~v + kNumItems'(1));
    endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Greedy change selection: the largest coin whose value does not exceed the balance.
module vm_change_picker
    import vending_machine_def::*;
#(
    parameter int TotalBits = kTotalBits
) (
    input  logic [TotalBits-1:0] total_i,
    input  logic [TotalBits-1:0] coin_table_i [kNumCoins],
    output logic [kNumCoins-1:0] coin_onehot_o,
    output logic [TotalBits-1:0] coin_value_o
);

    logic [kNumCoins-1:0] best_onehot;
    logic [TotalBits-1:0] best_value;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        best_onehot = '0;
        best_value  = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coin_table_i[i] <= total_i && coin_table_i[i] > best_value) begin
                best_onehot    = '0;
                best_onehot[i] = 1'b1;
                best_value     = coin_table_i[i];
            end
        end
    end

    assign coin_onehot_o = best_onehot;
    assign coin_value_o  = best_value;

endmodule

// File: rtl/vending_txn_controller.sv
// Vending transaction sequencer: balance, inactivity timer and change return.
// Optional: define VM_WAIT_RELOAD_ON_SELECT_EN so a granted item also reloads the timer.
module vending_txn_controller
    import vending_machine_def::*;
#(
    parameter int K_TOTAL_BITS = kTotalBits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [kNumCoins-1:0]    i_input_coin,
    input  logic [kNumItems-1:0]    i_select_item,
    input  logic                    i_trigger_return,
    output logic [kNumItems-1:0]    o_available_item,
    output logic [kNumItems-1:0]    o_output_item,
    output logic [kNumCoins-1:0]    o_return_coin,
    output logic [K_TOTAL_BITS-1:0] o_current_total,
    output logic [1:0]              o_state,
    output logic                    o_overflow
);

    localparam int kExtBits = K_TOTAL_BITS + 1;

    state_e                  state_q, state_d;
    logic [K_TOTAL_BITS-1:0] total_q, total_d;
    logic [kWaitBits-1:0]    wait_q, wait_d;
    logic [kNumItems-1:0]    output_item_q, output_item_d;
    logic [kNumCoins-1:0]    return_coin_q, return_coin_d;
    logic                    overflow_q, overflow_d;

    logic [K_TOTAL_BITS-1:0] coin_table [kNumCoins];
    logic [kNumCoins-1:0]    pick_onehot;
    logic [K_TOTAL_BITS-1:0] pick_value;
    logic [kExtBits-1:0]     coin_sum, total_ext;
    logic [K_TOTAL_BITS-1:0] t_prime, sel_price;
    logic [kNumItems-1:0]    sel_onehot;
    logic                    coin_ovf, coin_ok, grant, reload;

    always_comb begin
        for (int i = 0; i < kNumCoins; i++) begin
            coin_table[i] = K_TOTAL_BITS'(kCoinValue[i]);
        end
    end

    vm_change_picker #(.TotalBits(K_TOTAL_BITS)) u_change_picker (
        .total_i       (total_q),
        .coin_table_i  (coin_table),
        .coin_onehot_o (pick_onehot),
        .coin_value_o  (pick_value)
    );

    // Credit first (one extra bit exposes overflow), then price the request against t'.
    always_comb begin
        coin_sum = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (i_input_coin[i]) coin_sum = coin_sum + kExtBits'(kCoinValue[i]);
        end
        total_ext = {1'b0, total_q} + coin_sum;
        coin_ovf  = total_ext[K_TOTAL_BITS];
        coin_ok   = (|i_input_coin) && !coin_ovf;
        t_prime   = coin_ovf ? total_q : total_ext[K_TOTAL_BITS-1:0];

        sel_onehot = lowest_onehot(i_select_item);
        sel_price  = '0;
        for (int i = 0; i < kNumItems; i++) begin
            if (sel_onehot[i]) sel_price = K_TOTAL_BITS'(kItemPrice[i]);
        end
        grant = (|sel_onehot) && (sel_price <= t_prime);
`ifdef VM_WAIT_RELOAD_ON_SELECT_EN
        reload = coin_ok || grant;
`else
        reload = coin_ok;
`endif
    end

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        wait_d        = wait_q;
        output_item_d = '0;
        return_coin_d = '0;
        overflow_d    = 1'b0;
        case (state_q)
            RETURN: begin
                if (pick_onehot == '0) begin
                    state_d = IDLE;
                    wait_d  = '0;
                end else begin
                    return_coin_d = pick_onehot;
                    total_d       = total_q - pick_value;
                end
            end
            default: begin
                if (i_trigger_return) begin
                    state_d = RETURN;
                end else begin
                    overflow_d = (|i_input_coin) && coin_ovf;
                    total_d    = t_prime;
                    if (grant) begin
                        output_item_d = sel_onehot;
                        total_d       = t_prime - sel_price;
                    end
                    if (coin_ok) state_d = ACTIVE;
                    if (reload) begin
                        wait_d = kWaitBits'(kWaitTime);
                    end else if (state_q == ACTIVE) begin
                        wait_d = wait_q - kWaitBits'(1);
                        if (wait_q == kWaitBits'(1)) state_d = RETURN;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            total_q       <= '0;
            wait_q        <= '0;
            output_item_q <= '0;
            return_coin_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            wait_q        <= wait_d;
            output_item_q <= output_item_d;
            return_coin_q <= return_coin_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < kNumItems; i++) begin
            o_available_item[i] = (K_TOTAL_BITS'(kItemPrice[i]) <= total_q) && (state_q != RETURN);
        end
    end

    assign o_output_item   = output_item_q;
    assign o_return_coin   = return_coin_q;
    assign o_current_total = total_q;
    assign o_state         = state_q;
    assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_vending_txn_controller.sv
// Directed bench for vending_txn_controller; honours VM_WAIT_RELOAD_ON_SELECT_EN.
module tb_vending_txn_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic        i_trigger_return;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [2:0]  o_return_coin;
    logic [30:0] o_current_total;
    logic [1:0]  o_state;
    logic        o_overflow;

    // Narrow instance (max balance 2047) so the overflow boundary is reachable in a few cycles.
    logic [2:0]  ovf_input_coin;
    logic [3:0]  ovf_select_item;
    logic        ovf_trigger_return;
    logic [3:0]  ovf_available_item;
    logic [3:0]  ovf_output_item;
    logic [2:0]  ovf_return_coin;
    logic [10:0] ovf_current_total;
    logic [1:0]  ovf_state;
    logic        ovf_overflow;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vending_txn_controller dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_return_coin    (o_return_coin),
        .o_current_total  (o_current_total),
        .o_state          (o_state),
        .o_overflow       (o_overflow)
    );

    vending_txn_controller #(.K_TOTAL_BITS(11)) dut_ovf (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (ovf_input_coin),
        .i_select_item    (ovf_select_item),
        .i_trigger_return (ovf_trigger_return),
        .o_available_item (ovf_available_item),
        .o_output_item    (ovf_output_item),
        .o_return_coin    (ovf_return_coin),
        .o_current_total  (ovf_current_total),
        .o_state          (ovf_state),
        .o_overflow       (ovf_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_input_coin       = '0;
        i_select_item      = '0;
        i_trigger_return   = 1'b0;
        ovf_input_coin     = '0;
        ovf_select_item    = '0;
        ovf_trigger_return = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (o_state !== 2'b00) $display("FAIL reset_state: got %b expected 00", o_state); else n_pass++;
        n_total++; if (o_current_total !== 31'd0) $display("FAIL reset_total: got %0d expected 0", o_current_total); else n_pass++;
        n_total++; if (o_output_item !== 4'b0000 || o_return_coin !== 3'b000 || o_overflow !== 1'b0)
            $display("FAIL reset_outputs: got item=%b coin=%b ovf=%b expected all 0", o_output_item, o_return_coin, o_overflow); else n_pass++;
        n_total++; if (o_available_item !== 4'b0000) $display("FAIL reset_avail: got %b expected 0000", o_available_item); else n_pass++;
    endtask

    task automatic test_coin_insert();
        i_input_coin = 3'b100;
        step();
        i_input_coin = 3'b000;
        n_total++; if (o_current_total !== 31'd1000) $display("FAIL coin_total: got %0d expected 1000", o_current_total); else n_pass++;
        n_total++; if (o_state !== 2'b01) $display("FAIL coin_state: got %b expected 01", o_state); else n_pass++;
        n_total++; if (o_available_item !== 4'b0111) $display("FAIL coin_avail: got %b expected 0111", o_available_item); else n_pass++;
    endtask

    task automatic test_item_grant();
        i_select_item = 4'b0010;
        step();
        i_select_item = 4'b0000;
        n_total++; if (o_output_item !== 4'b0010) $display("FAIL grant_item: got %b expected 0010", o_output_item); else n_pass++;
        n_total++; if (o_current_total !== 31'd500) $display("FAIL grant_total: got %0d expected 500", o_current_total); else n_pass++;
        step();
        n_total++; if (o_output_item !== 4'b0000) $display("FAIL grant_pulse: got %b expected 0000", o_output_item); else n_pass++;
    endtask

    task automatic test_lowest_select();
        i_select_item = 4'b1000;
        step();
        n_total++; if (o_output_item !== 4'b0000) $display("FAIL unaffordable_item: got %b expected 0000", o_output_item); else n_pass++;
        n_total++; if (o_current_total !== 31'd500) $display("FAIL unaffordable_total: got %0d expected 500", o_current_total); else n_pass++;
        i_select_item = 4'b0011;
        step();
        i_select_item = 4'b0000;
        n_total++; if (o_output_item !== 4'b0001) $display("FAIL lowest_item: got %b expected 0001", o_output_item); else n_pass++;
        n_total++; if (o_current_total !== 31'd100) $display("FAIL lowest_total: got %0d expected 100", o_current_total); else n_pass++;
    endtask

    task automatic test_coin_and_select();
        // 100 + 500 credited first, then item0 (400) fits: 200 left.
        i_input_coin  = 3'b010;
        i_select_item = 4'b0001;
        step();
        idle_inputs();
        n_total++; if (o_output_item !== 4'b0001) $display("FAIL same_cycle_item: got %b expected 0001", o_output_item); else n_pass++;
        n_total++; if (o_current_total !== 31'd200) $display("FAIL same_cycle_total: got %0d expected 200", o_current_total); else n_pass++;
    endtask

    task automatic test_return_sequence();
        do_reset();
        i_input_coin = 3'b111;
        step();
        n_total++; if (o_current_total !== 31'd1600) $display("FAIL ret_load: got %0d expected 1600", o_current_total); else n_pass++;
        i_input_coin     = 3'b001;
        i_select_item    = 4'b0001;
        i_trigger_return = 1'b1;
        step();
        i_trigger_return = 1'b0;
        n_total++; if (o_state !== 2'b10) $display("FAIL ret_enter: got %b expected 10", o_state); else n_pass++;
        n_total++; if (o_current_total !== 31'd1600 || o_output_item !== 4'b0000)
            $display("FAIL ret_ignore: got total=%0d item=%b expected 1600 0000", o_current_total, o_output_item); else n_pass++;
        n_total++; if (o_available_item !== 4'b0000) $display("FAIL ret_avail: got %b expected 0000", o_available_item); else n_pass++;
        step();
        n_total++; if (o_return_coin !== 3'b100 || o_current_total !== 31'd600)
            $display("FAIL ret_coin1: got coin=%b total=%0d expected 100 600", o_return_coin, o_current_total); else n_pass++;
        step();
        n_total++; if (o_return_coin !== 3'b010 || o_current_total !== 31'd100)
            $display("FAIL ret_coin2: got coin=%b total=%0d expected 010 100", o_return_coin, o_current_total); else n_pass++;
        step();
        n_total++; if (o_return_coin !== 3'b001 || o_current_total !== 31'd0)
            $display("FAIL ret_coin3: got coin=%b total=%0d expected 001 0", o_return_coin, o_current_total); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (o_state !== 2'b00 || o_return_coin !== 3'b000 || o_current_total !== 31'd0)
            $display("FAIL ret_done: got state=%b coin=%b total=%0d expected 00 000 0", o_state, o_return_coin, o_current_total); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef VM_WAIT_RELOAD_ON_SELECT_EN
        i_input_coin = 3'b010;
        step();
        i_input_coin = 3'b000;
        for (int i = 1; i <= 4; i++) step();
        i_select_item = 4'b0001;
        step();
        i_select_item = 4'b0000;
        n_total++; if (o_output_item !== 4'b0001 || o_current_total !== 31'd100)
            $display("FAIL tmo_grant: got item=%b total=%0d expected 0001 100", o_output_item, o_current_total); else n_pass++;
        for (int i = 6; i <= 14; i++) step();
        n_total++; if (o_state !== 2'b01) $display("FAIL tmo_edge14: got %b expected 01", o_state); else n_pass++;
        step();
        n_total++; if (o_state !== 2'b10) $display("FAIL tmo_edge15: got %b expected 10", o_state); else n_pass++;
`else
        i_input_coin = 3'b001;
        step();
        i_input_coin = 3'b000;
        n_total++; if (o_state !== 2'b01 || o_current_total !== 31'd100)
            $display("FAIL tmo_insert: got state=%b total=%0d expected 01 100", o_state, o_current_total); else n_pass++;
        for (int i = 1; i <= 9; i++) step();
        n_total++; if (o_state !== 2'b01) $display("FAIL tmo_edge9: got %b expected 01", o_state); else n_pass++;
        step();
        n_total++; if (o_state !== 2'b10) $display("FAIL tmo_edge10: got %b expected 10", o_state); else n_pass++;
`endif
        step();
        n_total++; if (o_return_coin !== 3'b001 || o_current_total !== 31'd0)
            $display("FAIL tmo_change: got coin=%b total=%0d expected 001 0", o_return_coin, o_current_total); else n_pass++;
        step();
        n_total++; if (o_state !== 2'b00) $display("FAIL tmo_idle: got %b expected 00", o_state); else n_pass++;
    endtask

    task automatic test_reset_mid_return();
        do_reset();
        i_input_coin = 3'b111;
        step();
        i_input_coin     = 3'b000;
        i_trigger_return = 1'b1;
        step();
        i_trigger_return = 1'b0;
        step();
        n_total++; if (o_return_coin !== 3'b100) $display("FAIL midret_first: got %b expected 100", o_return_coin); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if (o_state !== 2'b00 || o_current_total !== 31'd0)
            $display("FAIL midret_state: got state=%b total=%0d expected 00 0", o_state, o_current_total); else n_pass++;
        n_total++; if (o_return_coin !== 3'b000 || o_output_item !== 4'b0000 || o_overflow !== 1'b0 || o_available_item !== 4'b0000)
            $display("FAIL midret_outputs: got coin=%b item=%b ovf=%b avail=%b expected all 0",
                     o_return_coin, o_output_item, o_overflow, o_available_item); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        ovf_input_coin = 3'b100;
        step();
        step();
        ovf_input_coin = 3'b000;
        n_total++; if (ovf_current_total !== 11'd2000 || ovf_overflow !== 1'b0)
            $display("FAIL ovf_fill: got total=%0d ovf=%b expected 2000 0", ovf_current_total, ovf_overflow); else n_pass++;
        ovf_input_coin = 3'b100;
        step();
        n_total++; if (ovf_overflow !== 1'b1 || ovf_current_total !== 11'd2000)
            $display("FAIL ovf_reject1000: got ovf=%b total=%0d expected 1 2000", ovf_overflow, ovf_current_total); else n_pass++;
        ovf_input_coin = 3'b001;
        step();
        n_total++; if (ovf_overflow !== 1'b1 || ovf_current_total !== 11'd2000)
            $display("FAIL ovf_reject100: got ovf=%b total=%0d expected 1 2000", ovf_overflow, ovf_current_total); else n_pass++;
        ovf_input_coin = 3'b000;
        step();
        n_total++; if (ovf_overflow !== 1'b0 || ovf_current_total !== 11'd2000)
            $display("FAIL ovf_pulse: got ovf=%b total=%0d expected 0 2000", ovf_overflow, ovf_current_total); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_coin_insert();
        test_item_grant();
        test_lowest_select();
        test_coin_and_select();
        test_return_sequence();
        test_timeout();
        test_reset_mid_return();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vending_txn_controller.md
Name: vending_txn_controller

Overview:
- Sequencing controller for the vending machine datapath.
- Owns the current_total register, the inactivity wait timer and the change-return sequencer.
- Each cycle it accepts coin/item events, grants one item per cycle and, on timeout or a user return request, dispenses change one coin per cycle.
- Sits between the user-facing I/O and the combinational total/availability logic.

Parameters:
- K_NUM_COINS, 3, number of coin types; coin value table {100, 500, 1000}, index 0..2.
- K_NUM_ITEMS, 4, number of item types; price table {400, 500, 1000, 2000}, index 0..3.
- K_TOTAL_BITS, 31, width of the total register.
- K_WAIT_TIME, 10, inactivity cycles before automatic return.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- i_input_coin  in  K_NUM_COINS  coins inserted this cycle; several bits may be set.
- i_select_item  in  K_NUM_ITEMS  item request; if several bits are set, only the lowest set index counts.
- i_trigger_return  in  1  user return request.
- o_available_item  out  K_NUM_ITEMS  combinational; price[i] <= o_current_total and state != RETURN.
- o_output_item  out  K_NUM_ITEMS  registered one-hot, one-cycle pulse when an item is granted.
- o_return_coin  out  K_NUM_COINS  registered one-hot, one coin per cycle during RETURN.
- o_current_total  out  K_TOTAL_BITS  registered balance.
- o_state  out  2  00 IDLE, 01 ACTIVE, 10 RETURN.
- o_overflow  out  1  registered one-cycle pulse when a coin insertion is rejected.

Behaviour:
- Reset (at the clock edge while reset=1, any state including mid-RETURN):
  - total=0, wait=0, state=IDLE.
  - o_output_item=0, o_return_coin=0, o_overflow=0.
- IDLE/ACTIVE, per edge:
  - sum = Σ coin_value[i] over set i_input_coin bits.
  - If total+sum exceeds 2^K_TOTAL_BITS-1: the whole insertion is rejected, total is unchanged, o_overflow pulses.
  - Otherwise t' = total+sum.
  - Selection uses k = lowest set bit of i_select_item. If price[k] <= t': o_output_item = one-hot k, total = t' − price[k]. Otherwise nothing is granted and total = t'.
  - Coin and selection in the same cycle: the coin is credited first, then the item is checked against t'.
- Wait timer:
  - Any accepted coin reloads wait=K_WAIT_TIME and forces state=ACTIVE.
  - In ACTIVE with no reload event: wait decrements.
  - When wait==1 and there is no reload event, the next state is RETURN.
  - i_trigger_return in IDLE/ACTIVE: next state RETURN, with priority over coin/select. Coins and selection arriving in that same cycle are ignored.
- RETURN, per edge:
  - o_return_coin = one-hot of the largest coin_value <= total; total decreases by that value.
  - If total < the smallest coin value: o_return_coin=0 and state goes to IDLE with wait=0. Any residual stays in total (it is always 0 with the default tables).
  - All inputs are ignored in RETURN.
- Width rule: all arithmetic is unsigned, K_TOTAL_BITS wide.
- Every registered output is 0 in any cycle without its event.

Optional Feature:
- Macro: VM_WAIT_RELOAD_ON_SELECT_EN.
- Defined: a granted item also reloads wait=K_WAIT_TIME.
- Undefined: only accepted coins reload the timer; a grant leaves wait counting down.

Decomposition:
- Shared package vending_machine_def holds:
  - kNumCoins, kNumItems, kTotalBits, kWaitTime;
  - coin value and item price tables;
  - state encodings IDLE/ACTIVE/RETURN.
- One natural sub-module: vm_change_picker, combinational. Takes total and the coin table; outputs the greedy one-hot coin and its value.

Test Plan:
1. After reset, insert i_input_coin=3'b100 for one cycle -> total=1000, state=ACTIVE, o_available_item=4'b0111.
2. With total=1000, i_select_item=4'b0010 -> next cycle o_output_item=4'b0010, total=500; following cycle o_output_item=0.
3. With total=500, i_select_item=4'b1000 -> no grant, total stays 500. i_select_item=4'b0011 with total=500 -> grants item0 only, total=100.
4. With total=1600, pulse i_trigger_return -> o_return_coin is 3'b100, 3'b010, 3'b001 on consecutive cycles, then state=IDLE with total=0.
5. Insert 100, then no input:
   - Macro undefined: state=RETURN exactly 10 edges after the insert edge; one cycle later o_return_coin=3'b001.
   - Macro defined: a grant at edge 5 delays entry into RETURN to edge 15.
6. Assert reset during the second RETURN cycle of scenario 4 -> at the next edge all outputs are 0 and state=IDLE. Also preload total near 2^31-1, insert 1000 -> o_overflow pulses and total is unchanged.
